// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back path.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;

    // One register-file write: enable, destination and value.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage : wb_pkg

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register with a long-latency
// write outstanding. A set and a clear of the same register in one cycle
// leave the bit set, because the new operation is still in flight.
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int NREG = wb_pkg::NREG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    output logic [NREG-1:0]       busy
);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                // x0 is never written, so it can never be pending.
                assign busy[gi] = 1'b0;
            end else begin : g_reg
                logic r_bit;
                logic w_set_hit;
                logic w_clr_hit;

                assign w_set_hit = set_en && (set_rd == REG_ADDR_W'(gi));
                assign w_clr_hit = clr_en && (clr_rd == REG_ADDR_W'(gi));

                // Busy bit: set has priority over clear in the same cycle.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_bit <= 1'b0;
                    end else begin
                        r_bit <= w_set_hit | (r_bit & ~w_clr_hit);
                    end
                end

                assign busy[gi] = r_bit;
            end
        end
    endgenerate

endmodule : wb_scoreboard

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: merges the unstallable pipeline stream (A) with
// long-latency results (B) through a one-entry hold buffer, raises a
// pipeline stall when the held result has lost arbitration too long, and
// tracks outstanding B writes for the hazard logic.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN         = wb_pkg::XLEN,
    parameter int NREG         = wb_pkg::NREG,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_rd,
    input  logic [XLEN-1:0]       a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_rd,
    input  logic [XLEN-1:0]       b_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic [NREG-1:0]       busy,
    output logic                  stall_req,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_rd,
    output logic [XLEN-1:0]       wr_data
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    wb_req_t    r_hold;
    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_cnt_next;
    logic       r_stall_req;

    logic       w_a_req;
    logic       w_grant_a;
    logic       w_grant_h;
    logic       w_accept;
    wb_req_t    w_wr;

    // Arbitration: A always wins; a write to x0 is no request, so the slot
    // falls to the hold buffer.
    always_comb begin
        w_a_req   = a_valid && (a_rd != '0);
        w_grant_a = w_a_req;
        w_grant_h = r_hold.valid && !w_a_req;
        // The buffer can refill in the same cycle it drains; nothing is
        // accepted while reset is held.
        b_ready   = rst && (!r_hold.valid || w_grant_h);
        w_accept  = b_valid && b_ready;
    end

    // Write-port mux; all write fields are zero when nothing is granted or
    // while reset is asserted (A passes straight through combinationally).
    always_comb begin
        w_wr = '0;
        if (rst) begin
            if (w_grant_a) begin
                w_wr.valid = 1'b1;
                w_wr.rd    = a_rd;
                w_wr.data  = a_data;
            end else if (w_grant_h) begin
                w_wr.valid = 1'b1;
                w_wr.rd    = r_hold.rd;
                w_wr.data  = r_hold.data;
            end
        end
    end

    assign wr_en   = w_wr.valid;
    assign wr_rd   = w_wr.rd;
    assign wr_data = w_wr.data;

    // Starvation counter: counts lost cycles of the held result, saturating.
    always_comb begin
        w_wait_cnt_next = r_wait_cnt;
        if (w_grant_h) begin
            w_wait_cnt_next = '0;
        end else if (r_hold.valid && (r_wait_cnt < LIMIT)) begin
            w_wait_cnt_next = r_wait_cnt + 4'd1;
        end
    end

    // Hold buffer: load on accept (x0 results are swallowed), empty on grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold <= '0;
        end else if (w_accept) begin
            r_hold.valid <= (b_rd != '0);
            r_hold.rd    <= b_rd;
            r_hold.data  <= b_data;
        end else if (w_grant_h) begin
            r_hold.valid <= 1'b0;
        end
    end

    // Counter and stall request: stall rises with the count reaching the
    // limit and drops at the edge after the held result is written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt  <= '0;
            r_stall_req <= 1'b0;
        end else begin
            r_wait_cnt  <= w_wait_cnt_next;
            r_stall_req <= (w_wait_cnt_next == LIMIT);
        end
    end

    assign stall_req = r_stall_req;

    wb_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk    (clk),
        .rst    (rst),
        .set_en (issue_valid && (issue_rd != '0)),
        .set_rd (issue_rd),
        .clr_en (w_grant_h),
        .clr_rd (r_hold.rd),
        .busy   (busy)
    );

endmodule : wb_port_arbiter

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] busy;
    logic        stall_req;
    logic        wr_en;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    wb_port_arbiter #(
        .XLEN (32), .NREG (32), .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (a_valid),
        .a_rd        (a_rd),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_rd        (b_rd),
        .b_data      (b_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
        .stall_req   (stall_req),
        .wr_en       (wr_en),
        .wr_rd       (wr_rd),
        .wr_data     (wr_data)
    );

    always #5 clk = ~clk;

    // Pipeline contract: A must be idle while a stall is requested.
    always @(negedge clk) begin
        if (rst === 1'b1 && stall_req === 1'b1) begin
            n_checks++;
            if (a_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL contract: a_valid=%b while stall_req=1 (required 0)", a_valid);
            end
        end
    end

    // One line per register-file write.
    always @(negedge clk) begin
        if (wr_en === 1'b1)
            $display("[%0t] write x%0d <= %08h", $time, wr_rd, wr_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        issue_valid = 0; issue_rd = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        a_valid = 1; a_rd = 5; a_data = 32'h11;
        b_valid = 1; b_rd = 9; b_data = 32'h99;
        issue_valid = 1; issue_rd = 3;
        tick(); tick();
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b need 0", wr_en); end
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready: got %b need 0", b_ready); end
        n_checks++; if (busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h need 0", busy); end
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b need 0", stall_req); end
        n_checks++; if (wr_rd !== 5'd0 || wr_data !== 32'd0) begin n_fail++; $display("FAIL reset_wr_fields: got %0d/%h need 0/0", wr_rd, wr_data); end
        b_valid = 0; issue_valid = 0;
        rst = 1;
        #1;
        n_checks++; if (wr_en !== 1'b1 || wr_rd !== 5'd5 || wr_data !== 32'h11) begin
            n_fail++; $display("FAIL reset_first_a: got %b/%0d/%h need 1/5/00000011", wr_en, wr_rd, wr_data); end
        tick();
        a_valid = 0;
        #1;
        n_checks++; if (wr_en !== 1'b0 || busy !== 32'h0) begin
            n_fail++; $display("FAIL reset_after_release: wr_en=%b busy=%h need 0/0 (nothing was accepted in reset)", wr_en, busy); end
    endtask

    task automatic test_idle_b();
        b_valid = 1; b_rd = 7; b_data = 32'hDEAD;
        #1;
        n_checks++; if (b_ready !== 1'b1 || wr_en !== 1'b0) begin
            n_fail++; $display("FAIL idle_b_accept: b_ready=%b wr_en=%b need 1/0", b_ready, wr_en); end
        tick();
        b_valid = 0;
        #1;
        n_checks++; if (wr_en !== 1'b1 || wr_rd !== 5'd7 || wr_data !== 32'hDEAD) begin
            n_fail++; $display("FAIL idle_b_write: got %b/%0d/%h need 1/7/0000dead", wr_en, wr_rd, wr_data); end
        tick();
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL idle_b_drain: wr_en=%b need 0", wr_en); end
    endtask

    task automatic test_back_to_back();
        b_valid = 1; b_rd = 8; b_data = 32'h80;
        tick();
        b_rd = 9; b_data = 32'h90;
        #1;
        n_checks++; if (b_ready !== 1'b1 || wr_en !== 1'b1 || wr_rd !== 5'd8 || wr_data !== 32'h80) begin
            n_fail++; $display("FAIL b2b_first: ready=%b wr=%b/%0d/%h need 1 1/8/00000080", b_ready, wr_en, wr_rd, wr_data); end
        tick();
        b_valid = 0;
        #1;
        n_checks++; if (wr_en !== 1'b1 || wr_rd !== 5'd9 || wr_data !== 32'h90) begin
            n_fail++; $display("FAIL b2b_second: wr=%b/%0d/%h need 1/9/00000090", wr_en, wr_rd, wr_data); end
        tick();
    endtask

    task automatic test_contention();
        b_valid = 1; b_rd = 3; b_data = 32'h33;
        tick();
        b_valid = 0;
        for (int k = 0; k < LIMIT; k++) begin
            a_valid = 1; a_rd = 5'(4 + k); a_data = 32'h400 + k;
            #1;
            n_checks++; if (wr_rd !== 5'(4 + k) || b_ready !== 1'b0 || stall_req !== 1'b0) begin
                n_fail++; $display("FAIL contention_loss%0d: wr_rd=%0d ready=%b stall=%b need %0d/0/0", k, wr_rd, b_ready, stall_req, 4 + k); end
            tick();
        end
        a_valid = 0;
        #1;
        n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL contention_stall: got %b need 1", stall_req); end
        n_checks++; if (wr_en !== 1'b1 || wr_rd !== 5'd3 || wr_data !== 32'h33) begin
            n_fail++; $display("FAIL contention_hold_write: got %b/%0d/%h need 1/3/00000033", wr_en, wr_rd, wr_data); end
        tick();
        n_checks++; if (stall_req !== 1'b0 || wr_en !== 1'b0) begin
            n_fail++; $display("FAIL contention_release: stall=%b wr_en=%b need 0/0", stall_req, wr_en); end
    endtask

    task automatic test_x0();
        b_valid = 1; b_rd = 6; b_data = 32'h66;
        tick();
        a_valid = 1; a_rd = 0; a_data = 32'h99;
        b_valid = 1; b_rd = 0; b_data = 32'hBAD;
        #1;
        n_checks++; if (wr_en !== 1'b1 || wr_rd !== 5'd6 || wr_data !== 32'h66 || b_ready !== 1'b1) begin
            n_fail++; $display("FAIL x0_hold_wins: got %b/%0d/%h ready=%b need 1/6/00000066 ready=1", wr_en, wr_rd, wr_data, b_ready); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (wr_en !== 1'b0 || b_ready !== 1'b1) begin
            n_fail++; $display("FAIL x0_b_discard: wr_en=%b ready=%b need 0/1", wr_en, b_ready); end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1; issue_rd = 12;
        tick();
        issue_valid = 0;
        n_checks++; if (busy !== 32'h1000) begin n_fail++; $display("FAIL sb_set: got %h need 00001000", busy); end
        b_valid = 1; b_rd = 12; b_data = 32'hC;
        tick();
        b_valid = 0;
        n_checks++; if (busy !== 32'h1000 || wr_rd !== 5'd12) begin
            n_fail++; $display("FAIL sb_held: busy=%h wr_rd=%0d need 00001000/12", busy, wr_rd); end
        tick();
        n_checks++; if (busy !== 32'h0) begin n_fail++; $display("FAIL sb_clear: got %h need 0", busy); end
        issue_valid = 1; issue_rd = 12;
        tick();
        issue_valid = 0;
        b_valid = 1; b_rd = 12; b_data = 32'hC2;
        tick();
        b_valid = 0;
        issue_valid = 1; issue_rd = 12;
        tick();
        issue_valid = 0;
        n_checks++; if (busy !== 32'h1000) begin n_fail++; $display("FAIL sb_set_wins: got %h need 00001000", busy); end
        issue_valid = 1; issue_rd = 0;
        tick();
        issue_valid = 0;
        n_checks++; if (busy !== 32'h1000) begin n_fail++; $display("FAIL sb_x0_issue: got %h need 00001000", busy); end
    endtask

    task automatic test_reset_mid_hold();
        a_valid = 1; a_rd = 1; a_data = 32'h1;
        b_valid = 1; b_rd = 20; b_data = 32'hABCD;
        tick();
        b_valid = 0;
        rst = 0;
        #1;
        n_checks++; if (busy !== 32'h0 || wr_en !== 1'b0 || b_ready !== 1'b0 || stall_req !== 1'b0) begin
            n_fail++; $display("FAIL midrst_state: busy=%h wr_en=%b ready=%b stall=%b need 0/0/0/0", busy, wr_en, b_ready, stall_req); end
        tick();
        a_valid = 0;
        rst = 1;
        #1;
        n_checks++; if (wr_en !== 1'b0 || b_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_dropped: wr_en=%b ready=%b need 0/1", wr_en, b_ready); end
        tick();
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_no_write: wr_en=%b need 0", wr_en); end
    endtask

    // Reference model: the held result is a queue of at most one entry, the
    // number of consecutive lost slots decides the stall, busy is a bitmap.
    typedef struct {logic [4:0] rd; logic [31:0] data;} held_t;

    task automatic test_random(input int cycles);
        held_t      q[$];
        int         lost   = 0;
        bit         stall  = 0;
        bit [31:0]  mbusy  = 0;
        bit         a_wins, h_wins, exp_ready, exp_en;
        logic [4:0] exp_rd;
        logic [31:0] exp_data;
        idle_inputs();
        rst = 0; tick(); rst = 1;
        for (int c = 0; c < cycles; c++) begin
            a_valid     = stall ? 1'b0 : ($urandom_range(0, 99) < 55);
            a_rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            a_data      = $urandom;
            b_valid     = ($urandom_range(0, 99) < 50);
            b_rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            b_data      = $urandom;
            issue_valid = ($urandom_range(0, 99) < 40);
            issue_rd    = 5'($urandom);
            a_wins    = a_valid && (a_rd != 0);
            h_wins    = (q.size() != 0) && !a_wins;
            exp_ready = (q.size() == 0) || h_wins;
            exp_en    = a_wins || h_wins;
            exp_rd    = a_wins ? a_rd   : (h_wins ? q[0].rd   : 5'd0);
            exp_data  = a_wins ? a_data : (h_wins ? q[0].data : 32'd0);
            #1;
            n_checks++; if (wr_en !== exp_en || wr_rd !== exp_rd || wr_data !== exp_data) begin
                n_fail++; $display("FAIL rand_write c%0d: got %b/%0d/%h need %b/%0d/%h", c, wr_en, wr_rd, wr_data, exp_en, exp_rd, exp_data); end
            n_checks++; if (b_ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_ready c%0d: got %b need %b", c, b_ready, exp_ready); end
            n_checks++; if (stall_req !== stall || busy !== mbusy) begin
                n_fail++; $display("FAIL rand_state c%0d: stall=%b busy=%h need %b/%h", c, stall_req, busy, stall, mbusy); end
            if (h_wins) begin
                mbusy[q[0].rd] = 1'b0;
                void'(q.pop_front());
                lost = 0;
            end else if (q.size() != 0) begin
                lost = (lost < LIMIT) ? lost + 1 : LIMIT;
            end
            if (issue_valid && issue_rd != 0) mbusy[issue_rd] = 1'b1;
            if (b_valid && exp_ready && b_rd != 0) q.push_back('{rd: b_rd, data: b_data});
            stall = (lost == LIMIT);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        #3;
        test_reset();
        test_idle_b();
        test_back_to_back();
        test_contention();
        test_x0();
        test_scoreboard();
        test_reset_mid_hold();
        test_random(600);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_wb_port_arbiter
